// File: rtl/spi_mem_sequencer.sv
// SPI memory transaction sequencer: runs on clk, consumes conditioned CS and
// SCLK edge pulses, and issues address-latch, shift-load and memory-write strobes.
module spi_mem_sequencer #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_en,
  output logic busy,
  output logic xfer_done
);

  localparam int AFRAME = ADDR_BITS + 1;
  localparam int CMAX   = (AFRAME > DATA_BITS) ? AFRAME : DATA_BITS;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int WW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(AFRAME - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  typedef enum logic [3:0] {
    IDLE, ADDR, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          cnt_inc;
  logic          done_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wcnt       <= '0;
      done_first <= 1'b0;
    end else begin
      state      <= state_n;
      done_first <= (state_n == DONE) && (state != DONE);
      // Both counters restart whenever the state changes
      if (state_n != state)  cnt <= '0;
      else if (cnt_inc)      cnt <= cnt + 1'b1;
      if (state_n != state)  wcnt <= '0;
      else if (state == RD_WAIT) wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_inc = 1'b0;
    if (cs) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      state_n = ADDR;
        ADDR: if (sclk_pos) begin
          cnt_inc = 1'b1;
          if (cnt == ADDR_LAST) state_n = LATCH;
        end
        // MEM_LAT==1 skips the wait state so sr_we lands one cycle after addr_we
        LATCH:     state_n = rw_bit ? ((MEM_LAT > 1) ? RD_WAIT : RD_LOAD) : WR_SHIFT;
        RD_WAIT:   if (wcnt == WAIT_LAST) state_n = RD_LOAD;
        RD_LOAD:   state_n = RD_SHIFT;
        RD_SHIFT: if (sclk_neg) begin
          cnt_inc = 1'b1;
          if (cnt == DATA_LAST) state_n = DONE;
        end
        WR_SHIFT: if (sclk_pos) begin
          cnt_inc = 1'b1;
          if (cnt == DATA_LAST) state_n = WR_COMMIT;
        end
        WR_COMMIT: state_n = DONE;
        DONE:      state_n = DONE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Moore outputs, all forced low the moment cs deselects
  assign addr_we   = ~cs & (state == LATCH);
  assign sr_we     = ~cs & (state == RD_LOAD);
  assign dm_we     = ~cs & (state == WR_COMMIT);
  assign miso_en   = ~cs & ((state == RD_LOAD) || (state == RD_SHIFT));
  assign busy      = ~cs & (state != IDLE) & (state != DONE);
  assign xfer_done = ~cs & (state == DONE) & done_first;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Randomized directed bench: two sequencers (MEM_LAT 1 and 3) share stimulus;
// expected strobes come from per-transaction event timing arithmetic.
module tb_spi_mem_sequencer;

  localparam int AB   = 7;
  localparam int DB   = 8;
  localparam int NMAX = 256;
  localparam int INF  = 1 << 20;

  logic clk, reset, cs, sclk_pos, sclk_neg, rw_bit;
  logic aw1, sw1, dw1, me1, bz1, xd1;
  logic aw3, sw3, dw3, me3, bz3, xd3;
  int   checks, failures;

  spi_mem_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .cs(cs), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .rw_bit(rw_bit), .addr_we(aw1), .sr_we(sw1), .dm_we(dw1), .miso_en(me1),
    .busy(bz1), .xfer_done(xd1));

  spi_mem_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .cs(cs), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .rw_bit(rw_bit), .addr_we(aw3), .sr_we(sw3), .dm_we(dw3), .miso_en(me3),
    .busy(bz3), .xfer_done(xd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [5:0] o1 = {aw1, sw1, dw1, me1, bz1, xd1};
  wire [5:0] o3 = {aw3, sw3, dw3, me3, bz3, xd3};

  task automatic chk(input string tag, input int r, input logic [5:0] obs,
                     input logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s r=%0d observed=%b expected=%b (aw,sw,dw,me,bz,xd)", tag, r, obs, expv);
    end
  endtask

  // Expected outputs at relative cycle r; cs fell at r=0, rose at r=X.
  // A = LATCH cycle, D = DONE entry cycle, cm = commit cycle (INF if absent).
  function automatic logic [5:0] exp_vec(int lat, int r, bit rd, int a, int d,
                                         int cm, int x);
    logic e_aw, e_sw, e_dw, e_me, e_bz, e_xd;
    if (r >= x) return 6'b0;
    e_aw = (r == a);
    e_sw = rd && (r == a + lat);
    e_dw = !rd && (r == cm);
    e_me = rd && (r >= a + lat) && (r < d);
    e_bz = (r > 0) && (r < d);
    e_xd = (r == d);
    return {e_aw, e_sw, e_dw, e_me, e_bz, e_xd};
  endfunction

  function automatic int gap();
    return int'($urandom_range(9, 6));
  endfunction

  // One transaction. Each loop iteration begins 1 time unit after a rising edge.
  task automatic xfer(input string tag, input bit rd, input int n_addr,
                      input int n_data, input bit stray, input bit rst_mid);
    bit pos_q [NMAX];
    bit neg_q [NMAX];
    int t, last, a, d, cm, x, hold;
    for (int i = 0; i < NMAX; i++) begin pos_q[i] = 1'b0; neg_q[i] = 1'b0; end
    a = INF; d = INF; cm = INF; last = 0;
    t = 1 + int'($urandom_range(3, 0));
    for (int i = 0; i < n_addr; i++) begin
      pos_q[t] = 1'b1;
      if (stray && i > 0) neg_q[t - 3] = 1'b1;
      last = t;
      t += gap();
    end
    if (n_addr == AB + 1) begin
      a = last + 1;
      t = a + gap();
      for (int i = 0; i < n_data; i++) begin
        if (rd) neg_q[t] = 1'b1; else pos_q[t] = 1'b1;
        last = t;
        t += gap();
      end
      if (n_data == DB) begin
        if (rd) d = last + 1;
        else begin cm = last + 1; d = last + 2; end
      end
    end
    if (d != INF) begin
      x = d + 2 + int'($urandom_range(3, 0));
      if (stray) begin pos_q[d + 1] = 1'b1; pos_q[x - 1] = 1'b1; end
    end else if (rst_mid) x = last + 3;
    else x = last + 1;
    hold = 1 + int'($urandom_range(2, 0));

    for (int r = 0; r < x + hold; r++) begin
      cs       = (r >= x);
      sclk_pos = pos_q[r];
      sclk_neg = neg_q[r];
      rw_bit   = (r == a) ? rd : 1'($urandom);
      #1;
      chk({tag, "_L1"}, r, o1, exp_vec(1, r, rd, a, d, cm, x));
      chk({tag, "_L3"}, r, o3, exp_vec(3, r, rd, a, d, cm, x));
      if (rst_mid && r == last + 2) begin
        sclk_pos = 1'b0; sclk_neg = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk({tag, "_async_L1"}, r, o1, 6'b0);
        chk({tag, "_async_L3"}, r, o3, 6'b0);
        cs = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    cs = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; cs = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_L1", 0, o1, 6'b0);
    chk("reset_L3", 0, o3, 6'b0);
    cs = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_L1", 0, o1, 6'b0);
    chk("idle_L3", 0, o3, 6'b0);

    xfer("write",        1'b0, AB + 1, DB, 1'b0, 1'b0);
    xfer("read",         1'b1, AB + 1, DB, 1'b0, 1'b0);
    xfer("read_stray",   1'b1, AB + 1, DB, 1'b1, 1'b0);
    xfer("write_stray",  1'b0, AB + 1, DB, 1'b1, 1'b0);
    xfer("abort_addr",   1'b0, 4,      0,  1'b0, 1'b0);
    xfer("after_abort",  1'b0, AB + 1, DB, 1'b0, 1'b0);
    xfer("abort_wdata",  1'b0, AB + 1, 5,  1'b0, 1'b0);
    xfer("abort_rdata",  1'b1, AB + 1, 3,  1'b0, 1'b0);
    xfer("rst_mid_read", 1'b1, AB + 1, 4,  1'b0, 1'b1);
    xfer("after_reset",  1'b1, AB + 1, DB, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bit rd;
      rd = 1'($urandom);
      xfer("rand", rd, AB + 1, DB, 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_sequencer.md
Name: spi_mem_sequencer

Overview:
- Cycle-accurate control FSM for the SPI-addressable data memory.
- Runs on the system clock `clk`. Consumes the conditioned chip-select level and single-cycle SCLK edge pulses from the input conditioners.
- Drives the write strobes for the address latch, the shift-register parallel load and the data memory, plus the MISO tri-state enable.
- Replaces direct SCLK-clocked sequencing: every transition is synchronous to `clk`.

Parameters:
- ADDR_BITS, 7, address bits shifted in before the R/W bit (address frame = ADDR_BITS+1 bits).
- DATA_BITS, 8, data bits per transfer.
- MEM_LAT, 1, `clk` cycles between the `addr_we` pulse and the `sr_we` pulse on reads (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- cs  input  1  conditioned chip select, 1 = deselected, 0 = selected.
- sclk_pos  input  1  one-`clk` pulse per SCLK rising edge.
- sclk_neg  input  1  one-`clk` pulse per SCLK falling edge.
- rw_bit  input  1  shift register bit 0; 1 = read, 0 = write.
- addr_we  output  1  address latch write enable, one-cycle pulse.
- sr_we  output  1  shift register parallel load, one-cycle pulse.
- dm_we  output  1  data memory write enable, one-cycle pulse.
- miso_en  output  1  MISO buffer enable, level.
- busy  output  1  high in any state other than IDLE and DONE.
- xfer_done  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high. All state and counter flops clear on reset.
- Reset/IDLE values: all outputs 0, bit counter 0.
- Outputs are Moore-decoded from state and gated by `~cs`, so `cs`=1 forces every output to 0 in the same cycle.
- Bit counter width: `$clog2(max(ADDR_BITS+1, DATA_BITS)+1)`. It clears on every state change.
- IDLE: `cs`=0 -> ADDR.
- ADDR:
  - Each `sclk_pos` increments the counter.
  - On the pulse that makes count = ADDR_BITS+1 -> LATCH.
- LATCH (1 cycle):
  - `addr_we`=1.
  - Sample `rw_bit`: 1 -> RD_WAIT, 0 -> WR_SHIFT.
- RD_WAIT: holds MEM_LAT-1 cycles (0 extra when MEM_LAT=1), then -> RD_LOAD.
- RD_LOAD (1 cycle): `sr_we`=1, `miso_en`=1 -> RD_SHIFT.
- RD_SHIFT:
  - `miso_en`=1.
  - Each `sclk_neg` increments the counter; count = DATA_BITS -> DONE.
- WR_SHIFT: each `sclk_pos` increments the counter; count = DATA_BITS -> WR_COMMIT.
- WR_COMMIT (1 cycle): `dm_we`=1 -> DONE.
- DONE: all strobes 0; `xfer_done`=1 on the entry cycle only. Stays in DONE until `cs`=1.
- Abort: `cs`=1 in any state -> IDLE on the next `clk` edge, counter cleared, no further strobes.
  - Partial writes never reach memory.
  - `cs`=1 in the WR_COMMIT cycle suppresses `dm_we`.
- Edge filtering:
  - `sclk_neg` is ignored outside RD_SHIFT.
  - `sclk_pos` is ignored outside ADDR and WR_SHIFT.
  - All SCLK pulses are ignored in IDLE, LATCH, RD_WAIT, RD_LOAD, WR_COMMIT and DONE.
  - Simultaneous `sclk_pos` and `sclk_neg` is illegal; the FSM uses only the pulse relevant to the current state.
- Timing constraint (on the SCLK source): SCLK half-period ≥ MEM_LAT+3 `clk` cycles. This guarantees RD_LOAD completes before the first data-phase `sclk_neg`.
- Back-to-back transactions: `cs` 0->1->0 with ≥1 `clk` cycle high gives DONE -> IDLE -> ADDR.
- Counters never wrap: the terminal count always changes state.

Test Plan:
- Write:
  - Stimulus: `cs`=0; 8 `sclk_pos` with `rw_bit`=0 at LATCH; then 8 `sclk_pos`.
  - Required: `addr_we` pulses exactly 1 cycle after the 8th address pulse; `dm_we` pulses exactly 1 cycle, 1 cycle after the 16th `sclk_pos`; `xfer_done` pulses the next cycle; `miso_en` stays 0 throughout.
- Read, MEM_LAT=1 and MEM_LAT=3:
  - Stimulus: 8 `sclk_pos` with `rw_bit`=1; then 8 `sclk_neg`.
  - Required: `sr_we` pulses exactly MEM_LAT cycles after `addr_we`; `miso_en` is high from the RD_LOAD cycle until DONE; `dm_we` never asserts.
- Abort in the address phase:
  - Stimulus: `cs`=1 after 4 `sclk_pos`.
  - Required: IDLE next cycle; `addr_we` never pulses. A new transaction after `cs`=0 needs the full 8 address pulses again.
- Abort in the write data phase:
  - Stimulus: `cs`=1 after 5 data `sclk_pos`.
  - Required: `dm_we` never asserts; `busy`=0 the next cycle.
- Asynchronous reset mid-read:
  - Stimulus: assert `reset` between `clk` edges during RD_SHIFT.
  - Required: `miso_en`=0 and `busy`=0 immediately, without waiting for a `clk` edge; counter=0.
- Stray edges:
  - Stimulus: `sclk_neg` pulses during ADDR; extra `sclk_pos` in DONE.
  - Required: the counter does not change; no strobes; FSM stays in DONE until `cs`=1.
